// File: rtl/vga_timing.sv
// 640x480@60 VGA raster generator: column/row counters plus registered sync,
// active-video and line/frame strobes, all aligned to the same pixel position.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] column,
  output logic [9:0] row,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_tick,
  output logic       frame_tick,
  output logic [7:0] frame_count
);

  // Both totals must fit the 10-bit counters (<= 1024).
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] col_next;
  logic [9:0] row_next;
  logic       frame_next;

  always_comb begin
    col_next = column + 10'd1;
    row_next = row;
    if (column == H_LAST) begin
      col_next = '0;
      row_next = (row == V_LAST) ? '0 : row + 10'd1;
    end
  end

  assign frame_next = (col_next == '0) && (row_next == V_ACT);

  // Decoding from the next-state counters keeps every registered output
  // describing the same position as column/row in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      column      <= H_LAST;
      row         <= V_LAST;
      video_on    <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      line_tick   <= 1'b0;
      frame_tick  <= 1'b0;
      frame_count <= '0;
    end else begin
      column     <= col_next;
      row        <= row_next;
      video_on   <= (col_next < H_ACT) && (row_next < V_ACT);
      hsync      <= !((col_next >= HS_FIRST) && (col_next <= HS_LAST));
      vsync      <= !((row_next >= VS_FIRST) && (row_next <= VS_LAST));
      line_tick  <= (col_next == '0);
      frame_tick <= frame_next;
      if (frame_next) frame_count <= frame_count + 8'd1;
    end
  end

endmodule
